// File: rtl/cla_seq_adder_if.sv
// Request, external-slice and result signals of the sequential CLA adder.
// The adder itself connects through the slave modport; its environment uses master.
interface cla_seq_adder_if #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_sub;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             slice_cin;
  logic [SLICE-1:0] slice_sum;
  logic             slice_cout;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             busy;

  modport slave (
    input  in_valid, in_sub, in_a, in_b, slice_sum, slice_cout, out_ready,
    output in_ready, slice_a, slice_b, slice_cin,
           out_valid, out_sum, out_cout, out_ovf, busy
  );

  modport master (
    output in_valid, in_sub, in_a, in_b, slice_sum, slice_cout, out_ready,
    input  in_ready, slice_a, slice_b, slice_cin,
           out_valid, out_sum, out_cout, out_ovf, busy
  );
endinterface

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit add/subtract that walks one external SLICE-bit CLA
// from the least- to the most-significant chunk, rippling carry through a register.
module cla_seq_adder #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input logic             clk,
  input logic             rst,
  cla_seq_adder_if.slave  bus
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = $clog2(N);
  localparam logic [KW-1:0] KLAST = KW'(N - 1);

  if ((WIDTH % SLICE) != 0 || N < 2) begin : g_bad_params
    $error("cla_seq_adder: WIDTH must be a multiple of SLICE with at least two chunks");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (k_q == KLAST)  state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is folded in at accept time: B is stored inverted and the
  // extra +1 enters as the carry-in of chunk 0.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    k_d     = k_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
          sub_d   = bus.in_sub;
          k_d     = '0;
          sum_d   = '0;
          carry_d = 1'b0;
        end
      end
      RUN: begin
        sum_d[k_q*SLICE +: SLICE] = bus.slice_sum;
        carry_d = bus.slice_cout;
        if (k_q != KLAST) k_d = k_q + KW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      k_q     <= k_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // Result outputs are gated to DONE so they read zero whenever no result is offered.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.busy      = 1'b0;
    bus.slice_a   = '0;
    bus.slice_b   = '0;
    bus.slice_cin = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_sum   = '0;
    bus.out_cout  = 1'b0;
    bus.out_ovf   = 1'b0;
    case (state_q)
      IDLE: bus.in_ready = 1'b1;
      RUN: begin
        bus.busy      = 1'b1;
        bus.slice_a   = a_q[k_q*SLICE +: SLICE];
        bus.slice_b   = b_q[k_q*SLICE +: SLICE];
        bus.slice_cin = (k_q == '0) ? sub_q : carry_q;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_sum   = sum_q;
        bus.out_cout  = carry_q;
        bus.out_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/cla_seq_adder.md
# cla_seq_adder

Multi-cycle 64-bit add/subtract sequencer that time-shares one external combinational CLA slice, e.g. a 16-bit slice built from four 4-bit PFA/CLA groups. Accepts one operation per handshake and walks the slice from least- to most-significant chunk, one chunk per cycle, rippling the slice carry through a register. Assembles the full result with carry-out and signed overflow. Sits between the operand-issue logic and the result consumer, so the full-width adder does not have to be instantiated.

## Interface
- WIDTH, 64, operand/result width; must be an integer multiple of SLICE.
- SLICE, 16, width of the external CLA slice; WIDTH/SLICE (N) must be ≥ 2.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high only in IDLE.
- in_sub  in  1  0 = A+B, 1 = A−B.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- slice_a  out  SLICE  chunk of A to the slice.
- slice_b  out  SLICE  chunk of B or ~B to the slice.
- slice_cin  out  1  slice carry-in.
- slice_sum  in  SLICE  slice sum, combinational from slice_a/b/cin.
- slice_cout  in  1  slice carry-out.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  final carry-out. For subtract, 1 = no borrow.
- out_ovf  out  1  two's-complement overflow.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch a_reg=in_a.
  - latch b_reg = in_sub ? ~in_b : in_b.
  - latch sub_reg=in_sub.
  - clear k=0 and the result register.
  - go to RUN.
- RUN:
  - slice_a = a_reg[k*SLICE +: SLICE].
  - slice_b = b_reg[k*SLICE +: SLICE].
  - slice_cin = (k==0) ? sub_reg : carry_reg.
  - Each cycle: sum_reg[k*SLICE +: SLICE] <= slice_sum; carry_reg <= slice_cout; k <= k+1.
  - When k==N−1, capture the last chunk and go to DONE.
- DONE:
  - out_valid=1.
  - out_sum=sum_reg and out_cout=carry_reg.
  - out_ovf = (a_reg[MSB]==b_reg[MSB]) & (sum_reg[MSB]!=a_reg[MSB]).
  - Outputs are held stable until out_valid & out_ready, then go to IDLE.
- Outside RUN, slice_a/slice_b/slice_cin are driven 0.
- k is a ceil(log2 N)-bit counter and never wraps past N−1.
- in_valid in RUN/DONE is ignored: no queuing, and in_* are not sampled.
- Reset, including mid-RUN or mid-DONE: state → IDLE. The in-flight operation is discarded with no partial result.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0, busy=0.
  - out_sum=0, out_cout=0, out_ovf=0.
  - slice_* = 0.
- Latency: accept at edge E0. Edges E1..EN capture chunks 0..N−1, and out_valid rises after EN. This is N cycles (4 at defaults).
- Throughput: at most one operation per N+2 cycles with out_ready held high. There is one IDLE cycle after the result handshake.
- out_ready high in the first DONE cycle: the result is consumed at that edge and in_ready=1 in the next cycle.
- out_ready low: DONE holds indefinitely, and all out_* are unchanged every cycle.
- The slice path is combinational within one cycle. This block adds no pipeline stage on it.

## Test plan
- Carry ripple: reset, then add in_a=0xFFFF_FFFF_FFFF_FFFF, in_b=1 → after 4 cycles out_sum=0, out_cout=1, out_ovf=0. slice_cin must be 0,1,1,1 across chunks 0..3.
- Signed overflow: add in_a=0x7FFF_FFFF_FFFF_FFFF, in_b=1 → out_sum=0x8000_0000_0000_0000, out_cout=0, out_ovf=1.
- Subtract with borrow: sub in_a=5, in_b=7 → out_sum=0xFFFF_FFFF_FFFF_FFFE, out_cout=0, out_ovf=0. Sub in_a=0x8000_0000_0000_0000, in_b=1 → out_ovf=1, out_cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, outputs constant, in_ready=0. Toggle in_valid with new operands in this window → no effect on the pending result.
- Reset mid-operation: assert rst during RUN at k=2 → next cycle state IDLE, out_valid=0, in_ready=1. A subsequent add 3+4 returns 7.
- Back-to-back with a randomized reference-model comparison: 1000 random add/sub with out_ready always 1 → each result matches A±B mod 2^64, and acceptances are spaced exactly N+2=6 cycles apart.
